// File: rtl/spinnaker_fpgas_reg_arbiter_if.sv
// Requester-side and register-bank-side signal bundle for spinnaker_fpgas_reg_arbiter.
// The master modport is the arbiter's view; the slave modport is the surrounding requesters and bank.
interface spinnaker_fpgas_reg_arbiter_if #(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32,
  parameter int NUM_REQ   = 2
);
  logic [NUM_REQ-1:0]           REQ_IN;
  logic [NUM_REQ-1:0]           REQ_WRITE_IN;
  logic [NUM_REQ*REGA_BITS-1:0] REQ_ADDR_IN;
  logic [NUM_REQ*REGD_BITS-1:0] REQ_WDATA_IN;
  logic [NUM_REQ-1:0]           ACK_OUT;
  logic [REGD_BITS-1:0]         RDATA_OUT;
  logic [NUM_REQ-1:0]           ERR_OUT;
  logic                         BANK_WRITE_OUT;
  logic [REGA_BITS-1:0]         BANK_ADDR_OUT;
  logic [REGD_BITS-1:0]         BANK_WDATA_OUT;
  logic [REGD_BITS-1:0]         BANK_RDATA_IN;

  modport master (
    input  REQ_IN, REQ_WRITE_IN, REQ_ADDR_IN, REQ_WDATA_IN, BANK_RDATA_IN,
    output ACK_OUT, RDATA_OUT, ERR_OUT, BANK_WRITE_OUT, BANK_ADDR_OUT, BANK_WDATA_OUT
  );

  modport slave (
    output REQ_IN, REQ_WRITE_IN, REQ_ADDR_IN, REQ_WDATA_IN, BANK_RDATA_IN,
    input  ACK_OUT, RDATA_OUT, ERR_OUT, BANK_WRITE_OUT, BANK_ADDR_OUT, BANK_WDATA_OUT
  );
endinterface

// File: rtl/spinnaker_fpgas_reg_arbiter.sv
// Round-robin arbiter sharing one register bank port between NUM_REQ requesters (IDLE -> ACCESS -> ACK).
// Optional macro REG_ARB_WRITE_PROTECT_EN blocks writes from requesters other than 0 at addresses >= WP_ADDR_LIMIT.
module spinnaker_fpgas_reg_arbiter #(
  parameter int REGA_BITS = 14,
  parameter int REGD_BITS = 32,
  parameter int NUM_REQ   = 2
`ifdef REG_ARB_WRITE_PROTECT_EN
  , parameter int WP_ADDR_LIMIT = 10
`endif
) (
  input logic CLK_IN,
  input logic RESET_IN,
  spinnaker_fpgas_reg_arbiter_if.master bus
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W:0]   NUM_REQ_EXT = (IDX_W+1)'(NUM_REQ);
  localparam logic [IDX_W-1:0] LAST_INIT   = IDX_W'(NUM_REQ - 1);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_ACK    = 2'd2;

  logic [1:0]           r_state;
  logic [IDX_W-1:0]     r_last;
  logic [IDX_W-1:0]     r_grant;
  logic                 r_wr;
  logic [NUM_REQ-1:0]   r_ack;
  logic [REGD_BITS-1:0] r_rdata;
  logic                 r_bank_write;
  logic [REGA_BITS-1:0] r_bank_addr;
  logic [REGD_BITS-1:0] r_bank_wdata;

  logic [REGA_BITS-1:0] w_addr_arr  [NUM_REQ];
  logic [REGD_BITS-1:0] w_wdata_arr [NUM_REQ];
  logic [IDX_W:0]       w_sum;
  logic                 w_hit;
  logic                 w_found;
  logic [IDX_W-1:0]     w_pick;
  logic                 w_wr_pick;
  logic                 w_wr_ok;
  logic [NUM_REQ-1:0]   w_grant_oh;

  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
    assign w_addr_arr[gi]  = bus.REQ_ADDR_IN[gi*REGA_BITS +: REGA_BITS];
    assign w_wdata_arr[gi] = bus.REQ_WDATA_IN[gi*REGD_BITS +: REGD_BITS];
  end

  // Round-robin search: first requester at or after (last+1) mod NUM_REQ, wrapping.
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_sum   = '0;
    w_hit   = 1'b0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      w_sum   = {1'b0, r_last} + (IDX_W+1)'(k);
      w_sum   = (w_sum >= NUM_REQ_EXT) ? (w_sum - NUM_REQ_EXT) : w_sum;
      w_hit   = ~w_found & bus.REQ_IN[w_sum[IDX_W-1:0]];
      w_pick  = w_hit ? w_sum[IDX_W-1:0] : w_pick;
      w_found = w_found | w_hit;
    end
  end

  assign w_wr_pick  = bus.REQ_WRITE_IN[w_pick];
  assign w_grant_oh = NUM_REQ'(1) << r_grant;

`ifdef REG_ARB_WRITE_PROTECT_EN
  logic               w_block;
  logic               r_block;
  logic [NUM_REQ-1:0] r_err;

  assign w_block = w_wr_pick & (w_pick != '0) &
                   (w_addr_arr[w_pick] >= REGA_BITS'(WP_ADDR_LIMIT));
  assign w_wr_ok = w_wr_pick & ~w_block;

  // Protection verdict is latched at grant and reported alongside the ACK.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_block <= 1'b0;
      r_err   <= '0;
    end else begin
      if ((r_state == ST_IDLE) && w_found) begin
        r_block <= w_block;
      end else begin
        r_block <= r_block;
      end
      if (r_state == ST_ACCESS) begin
        r_err <= r_block ? w_grant_oh : '0;
      end else begin
        r_err <= '0;
      end
    end
  end

  assign bus.ERR_OUT = r_err;
`else
  assign w_wr_ok     = w_wr_pick;
  assign bus.ERR_OUT = '0;
`endif

  // Main access sequencer; every bank-side and requester-side output is a register.
  always_ff @(posedge CLK_IN or posedge RESET_IN) begin
    if (RESET_IN) begin
      r_state      <= ST_IDLE;
      r_last       <= LAST_INIT;
      r_grant      <= '0;
      r_wr         <= 1'b0;
      r_ack        <= '0;
      r_rdata      <= '0;
      r_bank_write <= 1'b0;
      r_bank_addr  <= '0;
      r_bank_wdata <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          r_ack <= '0;
          if (w_found) begin
            r_grant      <= w_pick;
            r_last       <= w_pick;
            r_wr         <= w_wr_pick;
            r_bank_write <= w_wr_ok;
            r_bank_addr  <= w_addr_arr[w_pick];
            r_bank_wdata <= w_wdata_arr[w_pick];
            r_state      <= ST_ACCESS;
          end else begin
            r_bank_write <= 1'b0;
            r_state      <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          r_bank_write <= 1'b0;
          r_ack        <= w_grant_oh;
          r_rdata      <= r_wr ? r_rdata : bus.BANK_RDATA_IN;
          r_state      <= ST_ACK;
        end
        ST_ACK: begin
          r_ack   <= '0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_ack        <= '0;
          r_bank_write <= 1'b0;
          r_state      <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.ACK_OUT        = r_ack;
  assign bus.RDATA_OUT      = r_rdata;
  assign bus.BANK_WRITE_OUT = r_bank_write;
  assign bus.BANK_ADDR_OUT  = r_bank_addr;
  assign bus.BANK_WDATA_OUT = r_bank_wdata;

endmodule

// File: tb/tb_spinnaker_fpgas_reg_arbiter.sv
// Directed plus randomized bench for spinnaker_fpgas_reg_arbiter with a 64-word bank model
// and a round-robin reference model kept at transaction level.
module tb_spinnaker_fpgas_reg_arbiter;
  localparam int AW   = 14;
  localparam int DW   = 32;
  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  spinnaker_fpgas_reg_arbiter_if #(.REGA_BITS(AW), .REGD_BITS(DW), .NUM_REQ(NREQ)) bus ();

  spinnaker_fpgas_reg_arbiter #(.REGA_BITS(AW), .REGD_BITS(DW), .NUM_REQ(NREQ)) dut (
    .CLK_IN   (clk),
    .RESET_IN (rst),
    .bus      (bus)
  );

  // Register bank model: 64 words, address aliased on the low 6 bits, with a preload port.
  logic [DW-1:0] bank_mem [64];
  logic          pl_en;
  logic [5:0]    pl_addr;
  logic [DW-1:0] pl_data;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 64; i++) bank_mem[i] <= '0;
    end else if (pl_en) begin
      bank_mem[pl_addr] <= pl_data;
    end else if (bus.BANK_WRITE_OUT) begin
      bank_mem[bus.BANK_ADDR_OUT[5:0]] <= bus.BANK_WDATA_OUT;
    end
  end
  assign bus.BANK_RDATA_IN = bank_mem[bus.BANK_ADDR_OUT[5:0]];

  // Reference model state
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] ref_rdata;
  int            ref_last;
  logic          rq_wr   [NREQ];
  logic [AW-1:0] rq_addr [NREQ];
  logic [DW-1:0] rq_data [NREQ];

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int rr_pick(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      int c;
      c = (last + k) % NREQ;
      if (((m >> c) & 2'b01) != 2'b00) return c;
    end
    return -1;
  endfunction

  function automatic bit blocked(input int g);
`ifdef REG_ARB_WRITE_PROTECT_EN
    return rq_wr[g] && (g != 0) && (rq_addr[g] >= 14'd10);
`else
    return 1'b0;
`endif
  endfunction

  task automatic pack_ops();
    bus.REQ_WRITE_IN = {rq_wr[1], rq_wr[0]};
    bus.REQ_ADDR_IN  = {rq_addr[1], rq_addr[0]};
    bus.REQ_WDATA_IN = {rq_data[1], rq_data[0]};
  endtask

  task automatic reset_model();
    ref_last  = NREQ - 1;
    ref_rdata = '0;
    for (int i = 0; i < 64; i++) ref_mem[i] = '0;
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    bus.REQ_IN = '0;
    reset_model();
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
    pl_en   = 1'b1;
    pl_addr = a[5:0];
    pl_data = d;
    @(negedge clk);
    pl_en = 1'b0;
    ref_mem[a[5:0]] = d;
  endtask

  // Serve n_acc accesses for requesters in mask; called at a negedge with the DUT idle.
  task automatic run(input logic [NREQ-1:0] mask, input int n_acc, input bit rereq, input string tag);
    logic [NREQ-1:0] pending;
    pending = mask;
    pack_ops();
    bus.REQ_IN = mask;
    for (int k = 0; k < n_acc; k++) begin
      int g;
      g = rr_pick(pending, ref_last);
      if (g < 0) break;
      @(negedge clk);
      check({tag, "/access_write"}, bus.BANK_WRITE_OUT, rq_wr[g] && !blocked(g));
      check({tag, "/access_addr"}, bus.BANK_ADDR_OUT, rq_addr[g]);
      check({tag, "/access_wdata"}, bus.BANK_WDATA_OUT, rq_data[g]);
      check({tag, "/access_noack"}, bus.ACK_OUT, 0);
      @(negedge clk);
      if (!rq_wr[g]) ref_rdata = ref_mem[rq_addr[g][5:0]];
      else if (!blocked(g)) ref_mem[rq_addr[g][5:0]] = rq_data[g];
      check({tag, "/ack"}, bus.ACK_OUT, 2'b01 << g);
      check({tag, "/rdata"}, bus.RDATA_OUT, ref_rdata);
      check({tag, "/err"}, bus.ERR_OUT, blocked(g) ? (2'b01 << g) : 2'b00);
      check({tag, "/ack_write_low"}, bus.BANK_WRITE_OUT, 0);
      bus.REQ_IN = bus.REQ_IN & ~(2'b01 << g);
      ref_last = g;
      @(negedge clk);
      if (rereq && (k < n_acc - 1)) bus.REQ_IN = bus.REQ_IN | (2'b01 << g);
      else pending = pending & ~(2'b01 << g);
    end
    bus.REQ_IN = '0;
  endtask

  initial begin
    logic [NREQ-1:0] m;
    rst   = 1'b1;
    pl_en = 1'b0;
    pl_addr = '0;
    pl_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      rq_wr[i] = 1'b0; rq_addr[i] = '0; rq_data[i] = '0;
    end
    pack_ops();
    bus.REQ_IN = '0;
    reset_model();
    repeat (2) @(negedge clk);
    check("reset/ack", bus.ACK_OUT, 0);
    check("reset/err", bus.ERR_OUT, 0);
    check("reset/rdata", bus.RDATA_OUT, 0);
    check("reset/bank_write", bus.BANK_WRITE_OUT, 0);
    check("reset/bank_addr", bus.BANK_ADDR_OUT, 0);
    check("reset/bank_wdata", bus.BANK_WDATA_OUT, 0);
    rst = 1'b0;

    // Test 1/2: write by req0, readback by req1
    rq_wr[0] = 1'b1; rq_addr[0] = 14'd2; rq_data[0] = 32'h1234_5678;
    run(2'b01, 1, 1'b0, "t1_write");
    @(negedge clk);
    check("t1/strobe_one_cycle", bus.BANK_WRITE_OUT, 0);
    rq_wr[1] = 1'b0; rq_addr[1] = 14'd2; rq_data[1] = 32'h0;
    run(2'b10, 1, 1'b0, "t2_read");
    check("t2/rdata_value", bus.RDATA_OUT, 32'h1234_5678);

    // Test 3: contention from reset with immediate re-requests
    do_reset();
    rq_wr[0] = 1'b0; rq_addr[0] = 14'd1;
    rq_wr[1] = 1'b1; rq_addr[1] = 14'd3; rq_data[1] = 32'hCAFE_0001;
    run(2'b11, 4, 1'b1, "t3_rr");

    // Test 4: all-ones read, inputs changed after grant
    preload(14'h3FFF, 32'hFFFF_FFFF);
    rq_wr[0] = 1'b0; rq_addr[0] = 14'h3FFF; rq_data[0] = 32'h0;
    pack_ops();
    bus.REQ_IN = 2'b01;
    @(negedge clk);
    check("t4/access_addr", bus.BANK_ADDR_OUT, 14'h3FFF);
    bus.REQ_IN = '0;
    rq_addr[0] = 14'h0005;
    pack_ops();
    @(negedge clk);
    check("t4/ack", bus.ACK_OUT, 2'b01);
    check("t4/rdata", bus.RDATA_OUT, 32'hFFFF_FFFF);
    ref_rdata = 32'hFFFF_FFFF;
    ref_last  = 0;
    @(negedge clk);
    @(negedge clk);
    check("t4/no_regrant", bus.BANK_WRITE_OUT, 0);
    check("t4/no_ack", bus.ACK_OUT, 0);

    // Test 5: reset during ACCESS aborts the access
    rq_wr[0] = 1'b1; rq_addr[0] = 14'd3; rq_data[0] = $urandom;
    pack_ops();
    bus.REQ_IN = 2'b01;
    @(negedge clk);
    check("t5/access_write", bus.BANK_WRITE_OUT, 1);
    rst = 1'b1;
    bus.REQ_IN = '0;
    #1;
    check("t5/async_ack", bus.ACK_OUT, 0);
    check("t5/async_rdata", bus.RDATA_OUT, 0);
    check("t5/async_write", bus.BANK_WRITE_OUT, 0);
    check("t5/async_addr", bus.BANK_ADDR_OUT, 0);
    check("t5/async_wdata", bus.BANK_WDATA_OUT, 0);
    reset_model();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("t5/no_ack_1", bus.ACK_OUT, 0);
    @(negedge clk);
    check("t5/no_ack_2", bus.ACK_OUT, 0);
    rq_wr[0] = 1'b0; rq_addr[0] = 14'd4;
    rq_wr[1] = 1'b0; rq_addr[1] = 14'd5;
    run(2'b11, 2, 1'b0, "t5_after");

`ifdef REG_ARB_WRITE_PROTECT_EN
    // Test 6: write protection
    rq_wr[1] = 1'b1; rq_addr[1] = 14'd12; rq_data[1] = 32'hDEAD_BEEF;
    run(2'b10, 1, 1'b0, "t6_req1_blocked");
    rq_wr[0] = 1'b1; rq_addr[0] = 14'd12; rq_data[0] = 32'h0BAD_F00D;
    run(2'b01, 1, 1'b0, "t6_req0_allowed");
    rq_wr[1] = 1'b0; rq_addr[1] = 14'd12;
    run(2'b10, 1, 1'b0, "t6_readback");
`endif

    // Randomized contention rounds
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < NREQ; i++) begin
        rq_wr[i]   = 1'($urandom_range(0, 1));
        rq_addr[i] = 14'($urandom_range(0, 15));
        rq_data[i] = $urandom;
      end
      m = 2'($urandom_range(1, 3));
      run(m, $countones(m), 1'b0, "rnd");
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/spinnaker_fpgas_reg_arbiter.md
Name: spinnaker_fpgas_reg_arbiter

Overview:
Shares the single top-level control/diagnostic register bank port (WRITE/ADDR/WRITE_DATA/READ_DATA) between NUM_REQ independent requesters, e.g. the host SPI slave and the local debug/init sequencer. Uses round-robin arbitration with a per-requester request/acknowledge handshake. All bank-side signals are registered. Sits between the requester blocks and the register bank in the top-level FPGA design.

Parameters:
REGA_BITS, 14, register address width
REGD_BITS, 32, register data width
NUM_REQ, 2, number of requesters (2..8)

Ports:
CLK_IN  input  1  system clock
RESET_IN  input  1  asynchronous, active-high reset
REQ_IN  input  NUM_REQ  per-requester access request, level
REQ_WRITE_IN  input  NUM_REQ  per-requester access type: 1 = write, 0 = read
REQ_ADDR_IN  input  NUM_REQ*REGA_BITS  packed addresses; requester i at [i*REGA_BITS +: REGA_BITS]
REQ_WDATA_IN  input  NUM_REQ*REGD_BITS  packed write data, same packing
ACK_OUT  output  NUM_REQ  one-cycle completion pulse, per requester
RDATA_OUT  output  REGD_BITS  read data of the last completed access (shared)
ERR_OUT  output  NUM_REQ  one-cycle error pulse, coincident with ACK_OUT (feature only)
BANK_WRITE_OUT  output  1  register bank write strobe
BANK_ADDR_OUT  output  REGA_BITS  register bank address
BANK_WDATA_OUT  output  REGD_BITS  register bank write data
BANK_RDATA_IN  input  REGD_BITS  register bank combinational read data

Behaviour:
- Reset values: RESET_IN asynchronous, active-high; clock CLK_IN.
  - ACK_OUT = 0, ERR_OUT = 0, RDATA_OUT = 0.
  - BANK_WRITE_OUT = 0, BANK_ADDR_OUT = 0, BANK_WDATA_OUT = 0.
  - FSM = IDLE, last-grant pointer = NUM_REQ-1, so requester 0 has top priority first.
- FSM states:
  - IDLE: if any REQ_IN is high, pick the first requester with a high request, searching (last+1) mod NUM_REQ upward with wrap. Latch its index, write flag, address and data into the BANK_* registers, update the pointer, then go to ACCESS. Otherwise stay in IDLE.
  - ACCESS, 1 cycle: BANK_ADDR_OUT/BANK_WDATA_OUT are valid. BANK_WRITE_OUT = 1 iff the access is a permitted write. RDATA_OUT <= BANK_RDATA_IN for reads; RDATA_OUT is unchanged for writes. Go to ACK.
  - ACK, 1 cycle: ACK_OUT[grant] = 1 and RDATA_OUT is valid. Go to IDLE.
- Timing:
  - Request sampled in cycle N gives the bank strobe in N+1 and the ACK in N+2.
  - Maximum throughput is one access per 3 cycles.
- BANK_WRITE_OUT is high only in ACCESS. BANK_ADDR_OUT and BANK_WDATA_OUT hold their last values in IDLE/ACK.
- Handshake:
  - The requester holds REQ, type, address and data stable until it sees ACK.
  - It must drop REQ in the cycle ACK is high. REQ still high in the cycle after ACK counts as a new request.
  - Inputs are latched at grant, so deasserting REQ or changing data mid-transaction does not alter the access; ACK is still issued.
- Simultaneous requests are served strictly round-robin. A requester that re-requests immediately cannot starve others; worst-case wait is NUM_REQ-1 accesses.
- RDATA_OUT is shared; the requester must capture it on its own ACK cycle.
- Reset mid-ACCESS/ACK aborts the access: no ACK is issued and the FSM returns to IDLE. The bank itself sees reset concurrently.
- Unmapped addresses are not decoded here; read data is passed through as returned by the bank.

Optional Feature:
Macro REG_ARB_WRITE_PROTECT_EN.
- Defined:
  - Adds parameter WP_ADDR_LIMIT (default 10).
  - A write from any requester other than 0 to an address >= WP_ADDR_LIMIT proceeds through ACCESS with BANK_WRITE_OUT held 0.
  - In ACK it pulses ERR_OUT[grant] together with ACK_OUT[grant].
  - Reads are never blocked. Requester 0 is never blocked.
- Undefined: ERR_OUT is tied to 0, all writes pass, and the WP_ADDR_LIMIT logic is absent.

Test Plan:
1. After reset, req0 writes 0x12345678 to addr 2 -> BANK_WRITE_OUT high exactly one cycle with BANK_ADDR_OUT = 2 and BANK_WDATA_OUT = 0x12345678; ACK_OUT[0] two cycles after the sampled request.
2. req1 then reads addr 2 against a bank model -> RDATA_OUT = 0x12345678 on ACK_OUT[1], BANK_WRITE_OUT stays 0.
3. req0 and req1 both request in the same cycle from reset, each re-requesting immediately after its ACK -> grant order 0, 1, 0, 1 with no back-to-back repeats.
4. req0 reads addr 0x3FFF from a model returning 0xFFFFFFFF -> RDATA_OUT = 0xFFFFFFFF with ACK; req0 drops REQ and changes its address in ACCESS -> the access still completes at the latched address.
5. RESET_IN asserted during ACCESS -> no ACK_OUT, and all outputs return to 0 asynchronously; a new request afterwards goes to requester 0.
6. With REG_ARB_WRITE_PROTECT_EN defined, req1 writes addr 12 -> BANK_WRITE_OUT stays 0 and ERR_OUT[1] and ACK_OUT[1] both pulse; req0 writing addr 12 -> BANK_WRITE_OUT pulses and ERR_OUT stays 0.
